event_record_byte_tx: RTL and testbench

Transmit-side counterpart of the depth-parser record path. Accepts one unpacked event (ts_ns, update_id, side, price_f32, qty_f32) per AXI-Stream handshake and packs it into the canonical 256-bit event record. Serializes the record LSB-byte-first onto an 8-bit AXI-Stream toward the UART TX bridge, optionally preceded by a 2-byte sync word. Sits between the internal event generator / book logic and the UART transmitter, so host and PL exchange identical record images.

---
 rtl/event_record_types.sv | 44 ++++
 rtl/event_record_byte_tx.sv | 116 +++++++++++
 tb/tb_event_record_byte_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/event_record_types.sv
// Canonical 256-bit event record image: field offsets, widths and the packer.
// Both the TX serializer and any unpacker use these offsets so images match.
package event_record_types;

  localparam int REC_BITS  = 256;
  localparam int REC_BYTES = 32;

  localparam int TS_LSB    = 0;
  localparam int TS_W      = 64;
  localparam int UID_LSB   = 64;
  localparam int UID_W     = 64;
  localparam int SIDE_LSB  = 128;
  localparam int SIDE_W    = 8;
  localparam int PRICE_LSB = 136;
  localparam int PRICE_W   = 32;
  localparam int QTY_LSB   = 168;
  localparam int QTY_W     = 32;
  localparam int PAD_LSB   = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC0 = 2'd1,
    ST_SYNC1 = 2'd2,
    ST_DATA  = 2'd3
  } tx_state_t;

  function automatic logic [REC_BITS-1:0] pack_event_record(
    input logic [TS_W-1:0]    ts,
    input logic [UID_W-1:0]   uid,
    input logic [SIDE_W-1:0]  side,
    input logic [PRICE_W-1:0] price,
    input logic [QTY_W-1:0]   qty
  );
    logic [REC_BITS-1:0] r;
    r = '0;
    r[TS_LSB    +: TS_W]    = ts;
    r[UID_LSB   +: UID_W]   = uid;
    r[SIDE_LSB  +: SIDE_W]  = side;
    r[PRICE_LSB +: PRICE_W] = price;
    r[QTY_LSB   +: QTY_W]   = qty;
    return r;
  endfunction

endpackage

// File: rtl/event_record_byte_tx.sv
// Packs one event into the 256-bit record and streams it LSB byte first, optionally after a sync word.
// First byte valid the cycle after accept; output stalls hold all byte fields, input refused until the last byte handshakes.
module event_record_byte_tx
  import event_record_types::*;
#(
  parameter bit          SYNC_EN   = 1'b1,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ts_ns,
  input  logic [63:0] update_id,
  input  logic [7:0]  side,
  input  logic [31:0] price_f32,
  input  logic [31:0] qty_f32,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] rec_count,
  output logic        busy
);

  localparam tx_state_t START_STATE = SYNC_EN ? ST_SYNC0 : ST_DATA;

  tx_state_t           state, state_nxt;
  logic [4:0]          byte_idx, byte_idx_nxt;
  logic [REC_BITS-1:0] rec, rec_nxt;
  logic                last_cap, last_cap_nxt;
  logic                rec_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      byte_idx  <= '0;
      rec       <= '0;
      last_cap  <= 1'b0;
      rec_count <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_idx_nxt;
      rec      <= rec_nxt;
      last_cap <= last_cap_nxt;
      if (rec_done) rec_count <= rec_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    byte_idx_nxt  = byte_idx;
    rec_nxt       = rec;
    last_cap_nxt  = last_cap;
    rec_done      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // rst_n gates ready so the source sees no acceptance while held in reset
        s_axis_tready = rst_n;
        if (s_axis_tvalid) begin
          rec_nxt      = pack_event_record(ts_ns, update_id, side, price_f32, qty_f32);
          last_cap_nxt = s_axis_tlast;
          byte_idx_nxt = '0;
          state_nxt    = START_STATE;
        end
      end
      ST_SYNC0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = SYNC_WORD[7:0];
        if (m_axis_tready) state_nxt = ST_SYNC1;
      end
      ST_SYNC1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = SYNC_WORD[15:8];
        if (m_axis_tready) begin
          byte_idx_nxt = '0;
          state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = rec[{byte_idx, 3'b000} +: 8];
        m_axis_tlast  = (byte_idx == 5'd31);
        m_axis_tuser  = (byte_idx == 5'd31) && last_cap;
        if (m_axis_tready) begin
          byte_idx_nxt = byte_idx + 5'd1;
          if (byte_idx == 5'd31) begin
            // Next record is taken in the same cycle as the final byte so there is no bubble
            rec_done      = 1'b1;
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
              rec_nxt      = pack_event_record(ts_ns, update_id, side, price_f32, qty_f32);
              last_cap_nxt = s_axis_tlast;
              byte_idx_nxt = '0;
              state_nxt    = START_STATE;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_event_record_byte_tx.sv
// Directed bench for event_record_byte_tx: sync on and off, back-to-back, stalls, tuser and mid-record reset.
module tb_event_record_byte_tx;
  import event_record_types::*;

  typedef struct {
    logic [63:0] ts;
    logic [63:0] uid;
    logic [7:0]  sd;
    logic [31:0] price;
    logic [31:0] qty;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ts_ns, update_id;
  logic [7:0]  side;
  logic [31:0] price_f32, qty_f32;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [31:0] rec_count;
  logic        busy;

  logic        s0_tvalid, s0_tready;
  logic [7:0]  m0_tdata;
  logic        m0_tvalid, m0_tready, m0_tlast, m0_tuser;
  logic [31:0] rec_count0;
  logic        busy0;

  int total = 0;
  int bad = 0;

  ev_t         src_q[$];
  logic [7:0]  got_dat[$];
  bit          got_last[$];
  bit          got_user[$];
  int          accept_cyc[$];
  int          first_v, bubbles, stall_err, tready_bad;
  bit          timed_out;

  always #5 clk = ~clk;

  event_record_byte_tx #(.SYNC_EN(1'b1), .SYNC_WORD(16'hA55A)) dut (
    .clk(clk), .rst_n(rst_n), .ts_ns(ts_ns), .update_id(update_id), .side(side),
    .price_f32(price_f32), .qty_f32(qty_f32), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .rec_count(rec_count), .busy(busy)
  );

  event_record_byte_tx #(.SYNC_EN(1'b0), .SYNC_WORD(16'hA55A)) dut0 (
    .clk(clk), .rst_n(rst_n), .ts_ns(ts_ns), .update_id(update_id), .side(side),
    .price_f32(price_f32), .qty_f32(qty_f32), .s_axis_tvalid(s0_tvalid),
    .s_axis_tready(s0_tready), .s_axis_tlast(s_axis_tlast), .m_axis_tdata(m0_tdata),
    .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready), .m_axis_tlast(m0_tlast),
    .m_axis_tuser(m0_tuser), .rec_count(rec_count0), .busy(busy0)
  );

  // Drives the source from src_q and collects nbytes handshaken output bytes from dut.
  task automatic run(input int nbytes, input int max_cyc, input bit rnd);
    logic [7:0] hold_d;
    bit hold_l, hold_u, stalled;
    bit started;
    got_dat.delete(); got_last.delete(); got_user.delete(); accept_cyc.delete();
    first_v = -1; bubbles = 0; stall_err = 0; tready_bad = 0;
    stalled = 0; started = 0; hold_d = '0; hold_l = 0; hold_u = 0;
    for (int cyc = 0; cyc < max_cyc && got_dat.size() < nbytes; cyc++) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_q.size() > 0) begin
        s_axis_tvalid = 1'b1;
        ts_ns = src_q[0].ts; update_id = src_q[0].uid; side = src_q[0].sd;
        price_f32 = src_q[0].price; qty_f32 = src_q[0].qty; s_axis_tlast = src_q[0].last;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      #1;
      if (stalled && (!m_axis_tvalid || m_axis_tdata !== hold_d ||
                      m_axis_tlast !== hold_l || m_axis_tuser !== hold_u)) stall_err++;
      if (m_axis_tvalid && first_v < 0) first_v = cyc;
      if (m_axis_tvalid) started = 1;
      if (started && !m_axis_tvalid) bubbles++;
      if (busy && s_axis_tready && !(m_axis_tlast && m_axis_tready)) tready_bad++;
      if (s_axis_tvalid && s_axis_tready) begin
        accept_cyc.push_back(cyc);
        void'(src_q.pop_front());
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_dat.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        got_user.push_back(m_axis_tuser);
        stalled = 0;
      end else if (m_axis_tvalid) begin
        stalled = 1; hold_d = m_axis_tdata; hold_l = m_axis_tlast; hold_u = m_axis_tuser;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    timed_out = (got_dat.size() < nbytes);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 0; s0_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 1; m0_tready = 1;
    ts_ns = '0; update_id = '0; side = '0; price_f32 = '0; qty_f32 = '0;
    #12;
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready_low got=%b want=0", s_axis_tready); end
    @(posedge clk); #1 rst_n = 1'b1; #1;
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b want=1", s_axis_tready); end
    total++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy}); end
    total++; if (m_axis_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", m_axis_tdata); end
    total++; if (rec_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", rec_count); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [34] = '{8'h5A, 8'hA5,
      8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
      8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11,
      8'h01, 8'h00, 8'h00, 8'hC8, 8'h42, 8'h00, 8'h00, 8'h80, 8'h3F,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    src_q.push_back('{64'h0102030405060708, 64'h1112131415161718, 8'h01, 32'h42C80000, 32'h3F800000, 1'b0});
    run(34, 100, 0);
    total++; if (timed_out) begin bad++; $display("FAIL single_timeout got=%0d bytes want=34", got_dat.size()); end
    total++; if (accept_cyc.size() != 1 || first_v != accept_cyc[0] + 1) begin
      bad++; $display("FAIL single_latency first_valid=%0d want accept+1", first_v); end
    for (int i = 0; i < got_dat.size(); i++) begin
      total++; if (got_dat[i] !== exp_b[i] || got_last[i] !== (i == 33)) begin
        bad++; $display("FAIL single_byte%0d got=%h/%b want=%h/%b", i, got_dat[i], got_last[i], exp_b[i], i == 33); end
    end
    total++; if (rec_count !== 32'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_count got=%0d busy=%b want=1 busy=0", rec_count, busy); end
  endtask

  task automatic test_back_to_back();
    int nl;
    for (int r = 0; r < 3; r++)
      src_q.push_back('{64'h1000 + 64'(r), 64'h2000 + 64'(r), 8'(r), 32'h3F000000, 32'h40000000, 1'b0});
    run(102, 400, 0);
    nl = 0;
    foreach (got_last[i]) nl += got_last[i];
    total++; if (timed_out || bubbles != 0) begin
      bad++; $display("FAIL b2b_bubbles got=%0d bytes bubbles=%0d want=102/0", got_dat.size(), bubbles); end
    total++; if (rec_count !== 32'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", rec_count); end
    total++; if (tready_bad != 0 || accept_cyc.size() != 3) begin
      bad++; $display("FAIL b2b_tready stray=%0d accepts=%0d want=0/3", tready_bad, accept_cyc.size()); end
    total++; if (accept_cyc.size() == 3 && (accept_cyc[1] - accept_cyc[0] != 34 || accept_cyc[2] - accept_cyc[1] != 34)) begin
      bad++; $display("FAIL b2b_period got=%0d,%0d want=34,34", accept_cyc[1] - accept_cyc[0], accept_cyc[2] - accept_cyc[1]); end
    total++; if (nl != 3 || got_last[101] !== 1'b1) begin bad++; $display("FAIL b2b_tlast got=%0d want=3", nl); end
  endtask

  task automatic test_tuser();
    src_q.push_back('{64'hA, 64'hB, 8'h02, 32'h1, 32'h2, 1'b0});
    src_q.push_back('{64'hC, 64'hD, 8'h03, 32'h3, 32'h4, 1'b1});
    run(68, 300, 0);
    total++; if (timed_out) begin bad++; $display("FAIL tuser_timeout got=%0d want=68", got_dat.size()); end
    for (int i = 0; i < got_user.size(); i++) begin
      total++; if (got_user[i] !== (i == 67)) begin
        bad++; $display("FAIL tuser_byte%0d got=%b want=%b", i, got_user[i], i == 67); end
    end
  endtask

  task automatic test_backpressure();
    ev_t sent[$];
    ev_t e;
    logic [255:0] img;
    int base, rc0;
    bit ok;
    rc0 = int'(rec_count);
    for (int r = 0; r < 100; r++) begin
      e.ts = {$urandom, $urandom}; e.uid = {$urandom, $urandom}; e.sd = 8'($urandom);
      e.price = $urandom; e.qty = $urandom; e.last = 1'($urandom_range(0, 1));
      sent.push_back(e); src_q.push_back(e);
    end
    run(3400, 20000, 1);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=%0d want=3400", got_dat.size()); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable got=%0d unstable stalls want=0", stall_err); end
    total++; if (int'(rec_count) - rc0 != 100) begin bad++; $display("FAIL bp_count got=%0d want=100", int'(rec_count) - rc0); end
    for (int r = 0; r < 100 && !timed_out; r++) begin
      base = 34 * r;
      img = '0;
      for (int k = 0; k < 32; k++) img[8*k +: 8] = got_dat[base + 2 + k];
      ok = got_dat[base] === 8'h5A && got_dat[base + 1] === 8'hA5 &&
           img[TS_LSB +: TS_W] === sent[r].ts && img[UID_LSB +: UID_W] === sent[r].uid &&
           img[SIDE_LSB +: SIDE_W] === sent[r].sd && img[PRICE_LSB +: PRICE_W] === sent[r].price &&
           img[QTY_LSB +: QTY_W] === sent[r].qty && img[255:PAD_LSB] === '0 &&
           got_last[base + 33] === 1'b1 && got_user[base + 33] === sent[r].last;
      total++; if (!ok) begin
        bad++; $display("FAIL bp_rec%0d got ts=%h uid=%h want ts=%h uid=%h", r,
                        img[TS_LSB +: TS_W], img[UID_LSB +: UID_W], sent[r].ts, sent[r].uid); end
    end
  endtask

  task automatic test_sync_off();
    logic [7:0] b [$];
    bit l [$];
    bit acc;
    int extra;
    ts_ns = 64'h1122334455667788; update_id = 64'h99; side = 8'h05;
    price_f32 = 32'h1; qty_f32 = 32'h2; s_axis_tlast = 1'b0;
    s0_tvalid = 1'b1; m0_tready = 1'b1; acc = 0;
    for (int cyc = 0; cyc < 200 && b.size() < 32; cyc++) begin
      #1;
      if (s0_tvalid && s0_tready) acc = 1;
      if (m0_tvalid) begin b.push_back(m0_tdata); l.push_back(m0_tlast); end
      @(posedge clk); #1;
      if (acc) s0_tvalid = 1'b0;
    end
    extra = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin #1; extra += m0_tvalid; @(posedge clk); #1; end
    total++; if (b.size() != 32 || extra != 0) begin
      bad++; $display("FAIL nosync_len got=%0d+%0d want=32+0", b.size(), extra); end
    total++; if (b.size() > 0 && b[0] !== 8'h88) begin bad++; $display("FAIL nosync_first got=%h want=88", b[0]); end
    total++; if (b.size() == 32 && (l[31] !== 1'b1 || l[30] !== 1'b0)) begin
      bad++; $display("FAIL nosync_tlast got=%b%b want=01", l[30], l[31]); end
    total++; if (rec_count0 !== 32'd1) begin bad++; $display("FAIL nosync_count got=%0d want=1", rec_count0); end
  endtask

  task automatic test_mid_reset();
    int late;
    src_q.push_back('{64'hDEAD, 64'hBEEF, 8'h07, 32'h5, 32'h6, 1'b1});
    run(12, 100, 0);
    total++; if (timed_out || m_axis_tdata !== 8'h00 || !busy) begin
      bad++; $display("FAIL mreset_pre got=%h busy=%b want=00 busy=1", m_axis_tdata, busy); end
    rst_n = 1'b0; #1;
    total++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy} !== 5'b00000 ||
                 m_axis_tdata !== 8'h00 || rec_count !== 32'd0) begin
      bad++; $display("FAIL mreset_outputs got=%b data=%h cnt=%0d want=00000/00/0",
                      {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy}, m_axis_tdata, rec_count); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    late = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin #1; late += m_axis_tvalid; @(posedge clk); #1; end
    total++; if (late != 0 || rec_count !== 32'd0) begin
      bad++; $display("FAIL mreset_release got=%0d valid cycles cnt=%0d want=0/0", late, rec_count); end
    src_q.push_back('{64'h0102030405060708, 64'h0, 8'h00, 32'h0, 32'h0, 1'b0});
    run(33, 100, 0);
    total++; if (timed_out || got_dat[0] !== 8'h5A || got_dat[1] !== 8'hA5 || got_dat[2] !== 8'h08) begin
      bad++; $display("FAIL mreset_restart got=%h %h %h want=5a a5 08", got_dat[0], got_dat[1], got_dat[2]); end
    total++; if (rec_count !== 32'd0) begin bad++; $display("FAIL mreset_partial got=%0d want=0", rec_count); end
    run(1, 20, 0);
    total++; if (timed_out || got_last[0] !== 1'b1 || rec_count !== 32'd1) begin
      bad++; $display("FAIL mreset_complete got=%0d want=1", rec_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tuser();
    test_backpressure();
    test_sync_off();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
